// File: rtl/convertidor_binario_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter
// and the 7-segment display controller it feeds.
package convertidor_binario_bcd_pkg;

  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    DESPLAZAR = 2'd1,
    FIN       = 2'd2
  } estado_t;

  localparam int VALOR_MAX   = 9999;
  localparam int ANCHO_BCD   = 4;
  localparam int NUM_DIGITOS = 4;

endpackage

// File: rtl/convertidor_binario_bcd_suma3.sv
// Double-dabble correction: a BCD nibble of 5 or more
// gets +3 so the following shift carries into the next digit.
module suma3_bcd
  import convertidor_binario_bcd_pkg::*;
(
  input  logic [ANCHO_BCD-1:0] i_Nibble,
  output logic [ANCHO_BCD-1:0] o_Nibble
);

  assign o_Nibble = (i_Nibble >= 4'd5) ? i_Nibble + 4'd3
                                       : i_Nibble;

endmodule

// File: rtl/convertidor_binario_bcd.sv
// Iterative double-dabble converter: ANCHO-bit binary to four
// BCD digits, saturating at VALOR_MAX, with start/busy/done.
module convertidor_binario_bcd
  import convertidor_binario_bcd_pkg::*;
#(
  parameter int ANCHO     = 14,
  parameter int VALOR_MAX = convertidor_binario_bcd_pkg::VALOR_MAX
) (
  input  logic             i_Reloj,
  input  logic             i_Reset,
  input  logic             i_Inicio,
  input  logic [ANCHO-1:0] i_Binario,
  output logic [3:0]       o_Datos_0,
  output logic [3:0]       o_Datos_1,
  output logic [3:0]       o_Datos_2,
  output logic [3:0]       o_Datos_3,
  output logic             o_Ocupado,
  output logic             o_Listo,
  output logic             o_Desborde
);

  localparam int W_BCD = ANCHO_BCD * NUM_DIGITOS;
  localparam int CW    = $clog2(ANCHO + 1);

  estado_t          r_estado;
  estado_t          w_estado_sig;
  logic [ANCHO-1:0] r_binario;
  logic [W_BCD-1:0] r_bcd;
  logic [W_BCD-1:0] w_bcd_corr;
  logic [CW-1:0]    r_contador;
  logic             r_excede;
  logic [W_BCD-1:0] r_datos;
  logic             r_listo;
  logic             r_ocupado;
  logic             r_desborde;
  logic             w_excede;
  logic             w_ultimo;

  assign w_excede = 32'(i_Binario) > 32'(VALOR_MAX);
  assign w_ultimo = (r_contador == CW'(1));

  for (genvar g = 0; g < NUM_DIGITOS; g++) begin : g_suma3
    suma3_bcd u_suma3 (
      .i_Nibble (r_bcd[g*ANCHO_BCD +: ANCHO_BCD]),
      .o_Nibble (w_bcd_corr[g*ANCHO_BCD +: ANCHO_BCD])
    );
  end

  always_ff @(posedge i_Reloj or posedge i_Reset) begin
    if (i_Reset) r_estado <= REPOSO;
    else         r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      REPOSO:    if (i_Inicio) w_estado_sig = DESPLAZAR;
      DESPLAZAR: if (w_ultimo) w_estado_sig = FIN;
      FIN:       w_estado_sig = REPOSO;
      default:   w_estado_sig = REPOSO;
    endcase
  end

  always_ff @(posedge i_Reloj or posedge i_Reset) begin
    if (i_Reset) begin
      r_binario  <= '0;
      r_bcd      <= '0;
      r_contador <= '0;
      r_excede   <= 1'b0;
      r_datos    <= '0;
      r_listo    <= 1'b0;
      r_ocupado  <= 1'b0;
      r_desborde <= 1'b0;
    end else begin
      r_listo <= 1'b0;
      unique case (r_estado)
        REPOSO: begin
          if (i_Inicio) begin
            r_binario  <= w_excede ? ANCHO'(VALOR_MAX) : i_Binario;
            r_excede   <= w_excede;
            r_bcd      <= '0;
            r_contador <= CW'(ANCHO);
            r_ocupado  <= 1'b1;
          end
        end
        DESPLAZAR: begin
          // binary MSB falls into the BCD LSB
          {r_bcd, r_binario} <= {w_bcd_corr, r_binario} << 1;
          r_contador         <= r_contador - CW'(1);
        end
        FIN: begin
          r_datos    <= r_bcd;
          r_desborde <= r_excede;
          r_listo    <= 1'b1;
          r_ocupado  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_Datos_0  = r_datos[3:0];
  assign o_Datos_1  = r_datos[7:4];
  assign o_Datos_2  = r_datos[11:8];
  assign o_Datos_3  = r_datos[15:12];
  assign o_Ocupado  = r_ocupado;
  assign o_Listo    = r_listo;
  assign o_Desborde = r_desborde;

endmodule
